// File: rtl/cfg_loader_pkg.sv
// ============================================================================
// Module   : cfg_loader_pkg
// Purpose  : Shared state encoding and bitstream framing constants.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cfg_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COUNT   = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_COMMIT  = 3'd4,
        ST_ERROR   = 3'd5
    } state_e;

    localparam logic [7:0] SYNC_BYTE       = 8'hA5;
    localparam int         BYTES_PER_BLOCK = 3;
    localparam logic [7:0] RSV_MASK        = 8'hFC;

endpackage

`default_nettype wire

// File: rtl/cfg_frame_asm.sv
// ============================================================================
// Module   : cfg_frame_asm
// Purpose  : Packs three little-endian payload bytes into one block frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cfg_frame_asm
    import cfg_loader_pkg::*;
#(
    parameter int CFG_SIZE = 18
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic                byte_en_i,
    input  logic [7:0]          data_i,
    output logic [CFG_SIZE-1:0] frame_o,
    output logic                frame_valid_o,
    output logic                rsv_bad_o
);

    logic [1:0]  idx_q;
    logic [15:0] lo_q;
    logic        rsv_bad_q;
    logic        w_last;

    assign w_last        = byte_en_i && (idx_q == 2'(BYTES_PER_BLOCK - 1));
    assign frame_valid_o = w_last;
    // Third byte is combined on the fly so the frame is ready on the same edge.
    assign frame_o       = CFG_SIZE'({data_i, lo_q});
    assign rsv_bad_o     = rsv_bad_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= 2'd0;
            lo_q      <= 16'd0;
            rsv_bad_q <= 1'b0;
        end else if (clr_i) begin
            idx_q     <= 2'd0;
            lo_q      <= 16'd0;
            rsv_bad_q <= 1'b0;
        end else if (byte_en_i) begin
            if (w_last) begin
                idx_q <= 2'd0;
                if ((data_i & RSV_MASK) != 8'd0) begin
                    rsv_bad_q <= 1'b1;
                end
            end else begin
                idx_q <= idx_q + 2'd1;
                if (idx_q == 2'd0) begin
                    lo_q[7:0] <= data_i;
                end else begin
                    lo_q[15:8] <= data_i;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cfg_loader.sv
// ============================================================================
// Module   : cfg_loader
// Purpose  : Framed bitstream loader with checksum and atomic config commit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cfg_loader
    import cfg_loader_pkg::*;
#(
    parameter int NUM_BLOCKS = 16,
    parameter int CFG_SIZE   = 18,
    parameter int CNT_W      = $clog2(NUM_BLOCKS + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [7:0]                     in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [NUM_BLOCKS*CFG_SIZE-1:0] cfg_out,
    output logic                           fabric_en,
    output logic                           cfg_done,
    output logic                           cfg_err,
    output logic                           busy,
    output logic [CNT_W-1:0]               blocks_loaded
);

    localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    state_e                               state_q;
    logic [7:0]                           count_q;
    logic [7:0]                           blk_idx_q;
    logic [7:0]                           sum_q;
    logic [NUM_BLOCKS-1:0][CFG_SIZE-1:0]  shadow_q;
    logic [NUM_BLOCKS-1:0][CFG_SIZE-1:0]  active_q;
    logic                                 fabric_en_q;
    logic                                 cfg_done_q;
    logic                                 cfg_err_q;
    logic                                 committed_q;
    logic [CNT_W-1:0]                     blocks_loaded_q;

    logic                                 w_xfer;
    logic                                 w_sync;
    logic                                 w_pay;
    logic [CFG_SIZE-1:0]                  w_frame;
    logic                                 w_frame_valid;
    logic                                 w_rsv_bad;

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_COUNT) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
    assign w_xfer   = in_valid && in_ready;
    assign w_sync   = w_xfer && (state_q == ST_IDLE) && (in_data == SYNC_BYTE);
    assign w_pay    = w_xfer && (state_q == ST_PAYLOAD);

    cfg_frame_asm #(
        .CFG_SIZE (CFG_SIZE)
    ) u_frame_asm (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr_i         (w_sync),
        .byte_en_i     (w_pay),
        .data_i        (in_data),
        .frame_o       (w_frame),
        .frame_valid_o (w_frame_valid),
        .rsv_bad_o     (w_rsv_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            count_q         <= 8'd0;
            blk_idx_q       <= 8'd0;
            sum_q           <= 8'd0;
            shadow_q        <= '0;
            active_q        <= '0;
            fabric_en_q     <= 1'b0;
            cfg_done_q      <= 1'b0;
            cfg_err_q       <= 1'b0;
            committed_q     <= 1'b0;
            blocks_loaded_q <= '0;
        end else begin
            cfg_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_sync) begin
                        shadow_q    <= '0;
                        cfg_err_q   <= 1'b0;
                        fabric_en_q <= 1'b0;
                        blk_idx_q   <= 8'd0;
                        state_q     <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (w_xfer) begin
                        if ((in_data == 8'd0) || (int'(in_data) > NUM_BLOCKS)) begin
                            state_q <= ST_ERROR;
                        end else begin
                            count_q <= in_data;
                            sum_q   <= in_data;
                            state_q <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_xfer) begin
                        sum_q <= sum_q + in_data;
                        if (w_frame_valid) begin
                            shadow_q[blk_idx_q[IDX_W-1:0]] <= w_frame;
                            blk_idx_q <= blk_idx_q + 8'd1;
                            if (blk_idx_q == count_q - 8'd1) begin
                                state_q <= ST_CHECK;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_xfer) begin
                        state_q <= ((in_data == sum_q) && !w_rsv_bad) ? ST_COMMIT : ST_ERROR;
                    end
                end
                ST_COMMIT: begin
                    // Whole shadow is copied so blocks absent from this load read as zero.
                    active_q        <= shadow_q;
                    cfg_done_q      <= 1'b1;
                    blocks_loaded_q <= count_q[CNT_W-1:0];
                    committed_q     <= 1'b1;
                    fabric_en_q     <= 1'b1;
                    state_q         <= ST_IDLE;
                end
                ST_ERROR: begin
                    cfg_err_q   <= 1'b1;
                    fabric_en_q <= committed_q;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_out       = active_q;
    assign fabric_en     = fabric_en_q;
    assign cfg_done      = cfg_done_q;
    assign cfg_err       = cfg_err_q;
    assign busy          = (state_q != ST_IDLE);
    assign blocks_loaded = blocks_loaded_q;

endmodule

`default_nettype wire

// File: doc/cfg_loader.md
Name: cfg_loader

Overview:
- Configuration controller for an array of NUM_BLOCKS fabric logic blocks, each taking CFG_SIZE config bits (LUT memory, adder enable, flip-flop enable).
- Accepts a byte-wide framed bitstream over a valid/ready handshake and assembles per-block frames into a shadow store.
- Verifies a checksum, then commits all frames atomically to the active cfg bus that drives the logic blocks.
- Gates fabric operation via fabric_en while a load is in progress.

Parameters:
- NUM_BLOCKS, 16, number of logic blocks configured (1..255).
- CFG_SIZE, 18, config bits per logic block (fixed by the logic block; must be at most 24).
- CNT_W, $clog2(NUM_BLOCKS+1), width of blocks_loaded.

Ports:
- clk  in  1  fabric clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  8  bitstream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte; transfer when in_valid && in_ready.
- cfg_out  out  NUM_BLOCKS*CFG_SIZE  active config; block i uses bits [i*CFG_SIZE +: CFG_SIZE].
- fabric_en  out  1  high when a committed config exists and no load is in progress.
- cfg_done  out  1  one-cycle pulse on commit.
- cfg_err  out  1  sticky error; cleared on next accepted sync byte.
- busy  out  1  high in any state except IDLE.
- blocks_loaded  out  CNT_W  block count of the last successful commit.

Behaviour:
- Reset (async, rst_n low): state IDLE, cfg_out=0, shadow=0, fabric_en=0, cfg_done=0, cfg_err=0, blocks_loaded=0. No "committed" flag. Reset mid-load discards everything.
- Frame format: SYNC (8'hA5), COUNT, COUNT×3 payload bytes, CHK.
- Payload bytes are little-endian per block: byte0=cfg[7:0], byte1=cfg[15:8], byte2[1:0]=cfg[17:16]. byte2[7:2] are reserved and must be 0.
- Blocks are loaded in index order 0..COUNT-1.
- CHK = 8-bit sum mod 256 of COUNT and all payload bytes. SYNC is excluded.
- in_ready = 1 in IDLE, COUNT, PAYLOAD and CHECK; 0 in COMMIT and ERROR. in_ready is a function of state only.
- States:
  - IDLE: accepted bytes other than 8'hA5 are dropped. On SYNC: shadow cleared to 0, cfg_err cleared, fabric_en cleared, -> COUNT.
  - COUNT: COUNT=0 or COUNT>NUM_BLOCKS -> ERROR. Otherwise latch count, start running sum = COUNT, -> PAYLOAD.
  - PAYLOAD: byte index cycles 0,1,2. On byte2, write the assembled frame to shadow[block_idx] and increment block_idx. Any nonzero reserved bit sets an internal rsv_bad flag. After the last byte of block COUNT-1 -> CHECK.
  - CHECK: on the accepted CHK byte, if sum matches and !rsv_bad -> COMMIT, else -> ERROR.
  - COMMIT (1 cycle): cfg_out<=shadow (all blocks, so unloaded blocks become 0), cfg_done=1 for this cycle's registered output, blocks_loaded<=count, committed flag set, fabric_en<=1, -> IDLE.
  - ERROR (1 cycle): cfg_err<=1. fabric_en<=committed. cfg_out untouched. -> IDLE.
- Latency: CHK accepted at edge t; cfg_out, fabric_en and cfg_done change at edge t+1; cfg_done deasserts at t+2.
- The stream may stall (in_valid low) at any point indefinitely. No timeout.
- A SYNC value appearing inside a payload is data, not resync.
- cfg_out never changes except at COMMIT or reset.

Decomposition:
- Package cfg_loader_pkg holds:
  - state enum (IDLE, COUNT, PAYLOAD, CHECK, COMMIT, ERROR);
  - SYNC_BYTE = 8'hA5;
  - BYTES_PER_BLOCK = 3;
  - RSV_MASK = 8'hFC.
- Sub-module cfg_frame_asm: accumulates bytes 0..2 into a CFG_SIZE frame, emits frame_valid on byte2 and rsv_bad.
- Top level holds the FSM, counters, checksum and shadow/active stores.

Test Plan:
- Reset, then send A5,01,34,12,02,49 -> at edge after CHK: cfg_out[17:0]=18'h21234, all other blocks 0, cfg_done pulses 1 cycle, fabric_en=1, blocks_loaded=1.
- Load 16 blocks with block i cfg = i*18'h1111 (mod 2^18), correct CHK, random in_valid gaps -> cfg_out matches all 16 frames, exactly one cfg_done.
- After a good load, send A5,01,34,12,02,00 (bad CHK) -> cfg_err=1, cfg_out unchanged, fabric_en low during load and back to 1 after ERROR.
- Send A5,00 and A5,11 (COUNT 0 and 17) -> cfg_err=1 right after the COUNT byte, in_ready low 1 cycle, then IDLE. Next SYNC clears cfg_err.
- Byte2 = 8'h06 with correct sum -> error from reserved bits. Leading garbage 00,FF,5A before A5 is ignored and the load succeeds.
- Assert rst_n low mid-PAYLOAD -> all outputs 0 immediately. After release, a fresh full frame loads correctly.
